// File: rtl/pwm_ramp_sequencer_if.sv
// Host-side bundle for pwm_ramp_sequencer: ramp command pulses, PWM period tick,
// and the duty/status outputs. master = host/driver side, slave = sequencer.
interface pwm_ramp_sequencer_if #(
    parameter int DW = 8
);
    // No valid/ready pairs here: start, stop and cyc_end are single-cycle pulses
    // sampled on the rising clock edge; the command fields are sampled only on an
    // accepted start; duty_upd is a one-cycle strobe coincident with a duty change.
    logic          start;
    logic          stop;
    logic [DW-1:0] target_duty;
    logic [DW-1:0] step;
    logic [7:0]    dwell;
    logic          cyc_end;
    logic [DW-1:0] duty;
    logic          duty_upd;
    logic          busy;
    logic          done;
    logic [1:0]    dbg_state;

    modport master (
        output start, stop, target_duty, step, dwell, cyc_end,
        input  duty, duty_upd, busy, done, dbg_state
    );

    modport slave (
        input  start, stop, target_duty, step, dwell, cyc_end,
        output duty, duty_upd, busy, done, dbg_state
    );
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// Ramps the PWM duty toward a target in period-aligned steps, using cyc_end as timebase.
// Define PWM_SOFT_STOP_EN to make stop ramp duty down to 0 instead of freezing it.
module pwm_ramp_sequencer #(
    parameter int PERIOD = 10,
    parameter int DW     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    pwm_ramp_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STEP, S_DONE} state_t;

    localparam logic [DW-1:0] L_PERIOD = PERIOD[DW-1:0];
    localparam logic [DW-1:0] L_ONE    = {{(DW-1){1'b0}}, 1'b1};

    state_t        r_state;
    logic [DW-1:0] r_duty;
    logic [DW-1:0] r_tgt;
    logic [DW-1:0] r_step;
    logic [7:0]    r_dwell;
    logic [7:0]    r_dcnt;
    logic          r_up;
    logic          r_upd;
    logic          r_busy;
    logic          r_done;
`ifdef PWM_SOFT_STOP_EN
    logic          r_soft;
`endif

    logic          w_accept;
    logic          w_stop_act;
    logic [DW-1:0] w_tgt_in;
    logic [DW-1:0] w_step_in;
    logic [7:0]    w_dwell_in;
    logic [DW:0]   w_up_sum;
    logic [DW:0]   w_dn_lim;
    logic [DW-1:0] w_next;

    // stop outranks start, so a simultaneous pair never launches a ramp
    assign w_accept   = bus.start && !bus.stop && (r_state == S_IDLE || r_state == S_DONE);
    assign w_stop_act = bus.stop && (r_state == S_WAIT || r_state == S_STEP);
    assign w_tgt_in   = (bus.target_duty > L_PERIOD) ? L_PERIOD : bus.target_duty;
    assign w_step_in  = (bus.step == '0) ? L_ONE : bus.step;
    assign w_dwell_in = (bus.dwell == 8'd0) ? 8'd1 : bus.dwell;

    // One extra bit keeps both the overshoot test and the undershoot test wrap-free
    assign w_up_sum = {1'b0, r_duty} + {1'b0, r_step};
    assign w_dn_lim = {1'b0, r_tgt} + {1'b0, r_step};
    assign w_next   = r_up ? ((w_up_sum > {1'b0, r_tgt}) ? r_tgt : w_up_sum[DW-1:0])
                           : (({1'b0, r_duty} >= w_dn_lim) ? (r_duty - r_step) : r_tgt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_duty  <= '0;
            r_tgt   <= '0;
            r_step  <= '0;
            r_dwell <= 8'd0;
            r_dcnt  <= 8'd0;
            r_up    <= 1'b0;
            r_upd   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef PWM_SOFT_STOP_EN
            r_soft  <= 1'b0;
`endif
        end else begin
            r_upd <= 1'b0;
            if (w_stop_act) begin
`ifdef PWM_SOFT_STOP_EN
                if (r_soft) begin
                    r_duty  <= '0;
                    r_upd   <= (r_duty != '0);
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_soft  <= 1'b0;
                end else begin
                    r_soft <= 1'b1;
                    r_tgt  <= '0;
                    r_up   <= 1'b0;
                    if (r_duty == '0) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_state == S_STEP) begin
                        r_state <= S_WAIT;
                        r_dcnt  <= r_dwell;
                    end
                end
`else
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
`endif
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (w_accept) begin
                            r_tgt   <= w_tgt_in;
                            r_step  <= w_step_in;
                            r_dwell <= w_dwell_in;
`ifdef PWM_SOFT_STOP_EN
                            r_soft  <= 1'b0;
`endif
                            if (w_tgt_in == r_duty) begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_WAIT;
                                r_busy  <= 1'b1;
                                r_done  <= 1'b0;
                                r_dcnt  <= w_dwell_in;
                                r_up    <= (w_tgt_in > r_duty);
                            end
                        end
                    end
                    S_WAIT: begin
                        if (bus.cyc_end) begin
                            if (r_dcnt == 8'd1) begin
                                r_duty  <= w_next;
                                r_upd   <= 1'b1;
                                r_state <= S_STEP;
                            end else begin
                                r_dcnt <= r_dcnt - 8'd1;
                            end
                        end
                    end
                    S_STEP: begin
                        if (r_duty == r_tgt) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                            r_dcnt  <= r_dwell;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.duty      = r_duty;
    assign bus.duty_upd  = r_upd;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.dbg_state = r_state;
endmodule
